// File: rtl/sram_ctrl.sv
// Bus-to-async-SRAM bridge: one 32-bit request becomes one or two 16-bit SRAM
// half accesses with whole-cycle CE/OE/WE/LB/UB timing and a one-cycle ack.
module sram_ctrl #(
  parameter int RD_CYCLES = 1,
  parameter int WR_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] bus_addr,
  input  logic [3:0]  bus_be,
  input  logic [31:0] bus_wdata,
  input  logic        bus_rd,
  input  logic        bus_wr,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic [17:0] sram_addr,
  inout  wire  [15:0] sram_dq,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_lb_n,
  output logic        sram_ub_n
);

  // Bus handshake: bus_rd/bus_wr are held high until the cycle bus_ack pulses;
  // the requester drops them at the edge ending that cycle. bus_wr wins a tie.

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam int MAXC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] RD_LAST = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] WR_LAST = CW'(WR_CYCLES - 1);

  state_t        state, state_nxt;
  logic          half, half_nxt;
  logic [16:0]   addr_q, addr_nxt;
  logic [3:0]    be_q, be_nxt;
  logic [31:0]   wdata_q, wdata_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   rdata_nxt;
  logic          hi_pending;
  logic [1:0]    half_be;

  logic          ack_nxt;
  logic [17:0]   sram_addr_nxt;
  logic          ce_n_nxt, oe_n_nxt, we_n_nxt, lb_n_nxt, ub_n_nxt;
  logic [15:0]   dq_out, dq_out_nxt;
  logic          dq_oe, dq_oe_nxt;

  assign sram_dq = dq_oe ? dq_out : {16{1'bz}};

  always_comb begin
    state_nxt  = state;
    half_nxt   = half;
    addr_nxt   = addr_q;
    be_nxt     = be_q;
    wdata_nxt  = wdata_q;
    cnt_nxt    = cnt;
    rdata_nxt  = bus_rdata;
    hi_pending = ~half & (|be_q[3:2]);

    case (state)
      IDLE: begin
        if (bus_wr || bus_rd) begin
          addr_nxt  = bus_addr;
          be_nxt    = bus_be;
          wdata_nxt = bus_wdata;
          cnt_nxt   = '0;
          half_nxt  = ~(|bus_be[1:0]);
          if (bus_be == 4'h0)
            state_nxt = DONE;
          else if (bus_wr)
            state_nxt = WR_SETUP;
          else
            state_nxt = RD;
        end
      end
      RD: begin
        if (cnt == RD_LAST) begin
          // An unaccessed half reads back as zero.
          if (!half) begin
            rdata_nxt[15:0] = sram_dq;
            if (!(|be_q[3:2])) rdata_nxt[31:16] = '0;
          end else begin
            rdata_nxt[31:16] = sram_dq;
            if (!(|be_q[1:0])) rdata_nxt[15:0] = '0;
          end
          cnt_nxt = '0;
          if (hi_pending) begin
            half_nxt  = 1'b1;
            state_nxt = RD;
          end else begin
            state_nxt = DONE;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      WR_SETUP: begin
        cnt_nxt   = '0;
        state_nxt = WR_PULSE;
      end
      WR_PULSE: begin
        if (cnt == WR_LAST)
          state_nxt = WR_HOLD;
        else
          cnt_nxt = cnt + CW'(1);
      end
      WR_HOLD: begin
        if (hi_pending) begin
          half_nxt  = 1'b1;
          state_nxt = WR_SETUP;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Outputs are decoded from the next state so every pin comes from a flop.
    half_be       = half_nxt ? be_nxt[3:2] : be_nxt[1:0];
    ack_nxt       = 1'b0;
    sram_addr_nxt = sram_addr;
    ce_n_nxt      = 1'b1;
    oe_n_nxt      = 1'b1;
    we_n_nxt      = 1'b1;
    lb_n_nxt      = 1'b1;
    ub_n_nxt      = 1'b1;
    dq_out_nxt    = dq_out;
    dq_oe_nxt     = 1'b0;

    case (state_nxt)
      RD: begin
        sram_addr_nxt = {addr_nxt, half_nxt};
        ce_n_nxt      = 1'b0;
        oe_n_nxt      = 1'b0;
        lb_n_nxt      = ~half_be[0];
        ub_n_nxt      = ~half_be[1];
      end
      WR_SETUP, WR_PULSE, WR_HOLD: begin
        sram_addr_nxt = {addr_nxt, half_nxt};
        ce_n_nxt      = 1'b0;
        we_n_nxt      = (state_nxt != WR_PULSE);
        lb_n_nxt      = ~half_be[0];
        ub_n_nxt      = ~half_be[1];
        dq_out_nxt    = half_nxt ? wdata_nxt[31:16] : wdata_nxt[15:0];
        dq_oe_nxt     = 1'b1;
      end
      DONE:    ack_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      half      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
      bus_rdata <= '0;
      bus_ack   <= 1'b0;
      sram_addr <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_lb_n <= 1'b1;
      sram_ub_n <= 1'b1;
      dq_out    <= '0;
      dq_oe     <= 1'b0;
    end else begin
      state     <= state_nxt;
      half      <= half_nxt;
      addr_q    <= addr_nxt;
      be_q      <= be_nxt;
      wdata_q   <= wdata_nxt;
      cnt       <= cnt_nxt;
      bus_rdata <= rdata_nxt;
      bus_ack   <= ack_nxt;
      sram_addr <= sram_addr_nxt;
      sram_ce_n <= ce_n_nxt;
      sram_oe_n <= oe_n_nxt;
      sram_we_n <= we_n_nxt;
      sram_lb_n <= lb_n_nxt;
      sram_ub_n <= ub_n_nxt;
      dq_out    <= dq_out_nxt;
      dq_oe     <= dq_oe_nxt;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: two instances (default timing and RD=3/WR=2), each with a
// behavioural async SRAM and a word-level reference memory.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic [16:0] bus_addr  [2];
  logic [3:0]  bus_be    [2];
  logic [31:0] bus_wdata [2];
  logic        bus_rd    [2];
  logic        bus_wr    [2];
  logic [31:0] bus_rdata [2];
  logic        bus_ack   [2];
  logic [17:0] sram_addr [2];
  logic        sram_ce_n [2];
  logic        sram_oe_n [2];
  logic        sram_we_n [2];
  logic        sram_lb_n [2];
  logic        sram_ub_n [2];
  wire  [15:0] dq0, dq1;

  bit   [15:0] sram_mem [2][262144];
  bit   [15:0] ref_mem  [2][262144];
  logic [31:0] exp_q[$];
  logic [31:0] last_rd [2];

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;

  sram_ctrl #(.RD_CYCLES(1), .WR_CYCLES(1)) u_dut_fast (
    .clk(clk), .rst(rst[0]), .bus_addr(bus_addr[0]), .bus_be(bus_be[0]),
    .bus_wdata(bus_wdata[0]), .bus_rd(bus_rd[0]), .bus_wr(bus_wr[0]),
    .bus_rdata(bus_rdata[0]), .bus_ack(bus_ack[0]), .sram_addr(sram_addr[0]),
    .sram_dq(dq0), .sram_ce_n(sram_ce_n[0]), .sram_oe_n(sram_oe_n[0]),
    .sram_we_n(sram_we_n[0]), .sram_lb_n(sram_lb_n[0]), .sram_ub_n(sram_ub_n[0])
  );

  sram_ctrl #(.RD_CYCLES(3), .WR_CYCLES(2)) u_dut_slow (
    .clk(clk), .rst(rst[1]), .bus_addr(bus_addr[1]), .bus_be(bus_be[1]),
    .bus_wdata(bus_wdata[1]), .bus_rd(bus_rd[1]), .bus_wr(bus_wr[1]),
    .bus_rdata(bus_rdata[1]), .bus_ack(bus_ack[1]), .sram_addr(sram_addr[1]),
    .sram_dq(dq1), .sram_ce_n(sram_ce_n[1]), .sram_oe_n(sram_oe_n[1]),
    .sram_we_n(sram_we_n[1]), .sram_lb_n(sram_lb_n[1]), .sram_ub_n(sram_ub_n[1])
  );

  // SRAM read drive: whole word whenever selected and output-enabled.
  assign dq0 = (!sram_ce_n[0] && !sram_oe_n[0] && sram_we_n[0]) ? sram_mem[0][sram_addr[0]] : 16'hzzzz;
  assign dq1 = (!sram_ce_n[1] && !sram_oe_n[1] && sram_we_n[1]) ? sram_mem[1][sram_addr[1]] : 16'hzzzz;

  function automatic int rd_cyc(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int wr_cyc(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // SRAM write model and pin-level protocol checks, sampled mid-cycle.
  logic        prev_we   [2];
  logic [17:0] prev_addr [2];
  logic        pend_v    [2];
  logic [17:0] pend_a    [2];
  logic [15:0] pend_d    [2];
  logic        pend_lb   [2];
  logic        pend_ub   [2];
  int          we_len    [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mon_en) begin
        if (!sram_we_n[i] && prev_we[i])
          check("we_fall_addr", 32'(sram_addr[i]), 32'(prev_addr[i]));
        if (!sram_oe_n[i])
          check("oe_vs_we", 32'(sram_we_n[i]), 32'd1);
        if (!sram_we_n[i] && !sram_ce_n[i]) begin
          pend_v[i]  = 1'b1;
          pend_a[i]  = sram_addr[i];
          pend_d[i]  = (i == 0) ? dq0 : dq1;
          pend_lb[i] = sram_lb_n[i];
          pend_ub[i] = sram_ub_n[i];
          we_len[i]  = we_len[i] + 1;
        end
        if (sram_we_n[i] && !prev_we[i] && pend_v[i]) begin
          if (!pend_lb[i]) sram_mem[i][pend_a[i]][7:0]  = pend_d[i][7:0];
          if (!pend_ub[i]) sram_mem[i][pend_a[i]][15:8] = pend_d[i][15:8];
          check("we_width", 32'(we_len[i]), 32'(wr_cyc(i)));
          pend_v[i] = 1'b0;
          we_len[i] = 0;
        end
      end
      prev_we[i]   = sram_we_n[i];
      prev_addr[i] = sram_addr[i];
    end
  end

  // One bus transaction, driven and sampled on the falling edge.
  task automatic do_txn(input int i, input logic wr, input logic rd, input logic [16:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
    int h, lat, exp_lat, ce_cnt, oe_cnt, we_cnt, exp_ce, exp_oe, exp_we;
    bit got_ack;
    logic [31:0] exp_rd, got_q;
    logic [17:0] ha;
    h = int'(|be[1:0]) + int'(|be[3:2]);
    if (be == 4'h0)  exp_lat = 1;
    else if (wr)     exp_lat = h * (wr_cyc(i) + 2) + 1;
    else             exp_lat = h * rd_cyc(i) + 1;
    exp_ce = (be == 4'h0) ? 0 : (wr ? h * (wr_cyc(i) + 2) : h * rd_cyc(i));
    exp_oe = (!wr && be != 4'h0) ? h * rd_cyc(i) : 0;
    exp_we = wr ? h * wr_cyc(i) : 0;
    if (!wr && be != 4'h0) begin
      exp_rd[15:0]  = (|be[1:0]) ? ref_mem[i][{a, 1'b0}] : 16'h0;
      exp_rd[31:16] = (|be[3:2]) ? ref_mem[i][{a, 1'b1}] : 16'h0;
      exp_q.push_back(exp_rd);
      last_rd[i] = exp_rd;
    end
    if (wr) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) begin
          ha = {a, (k >= 2)};
          if (k % 2 == 0) ref_mem[i][ha][7:0]  = wd[8*k +: 8];
          else            ref_mem[i][ha][15:8] = wd[8*k +: 8];
        end
      end
    end
    bus_addr[i] = a; bus_be[i] = be; bus_wdata[i] = wd;
    bus_wr[i] = wr; bus_rd[i] = rd;
    lat = 0; ce_cnt = 0; oe_cnt = 0; we_cnt = 0; got_ack = 1'b0;
    while (!got_ack && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      ce_cnt += int'(!sram_ce_n[i]);
      oe_cnt += int'(!sram_oe_n[i]);
      we_cnt += int'(!sram_we_n[i]);
      if (bus_ack[i]) got_ack = 1'b1;
    end
    bus_wr[i] = 1'b0; bus_rd[i] = 1'b0;
    check("ack_seen", 32'(got_ack), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("ce_cycles", 32'(ce_cnt), 32'(exp_ce));
    check("oe_cycles", 32'(oe_cnt), 32'(exp_oe));
    check("we_cycles", 32'(we_cnt), 32'(exp_we));
    if (!wr && be != 4'h0) begin
      got_q = exp_q.pop_front();
      check("rdata", bus_rdata[i], got_q);
    end else begin
      check("rdata_hold", bus_rdata[i], last_rd[i]);
    end
    @(posedge clk);
    @(negedge clk);
    check("ack_pulse", 32'(bus_ack[i]), 32'd0);
    if (wr) begin
      check("mem_lo", 32'(sram_mem[i][{a, 1'b0}]), 32'(ref_mem[i][{a, 1'b0}]));
      check("mem_hi", 32'(sram_mem[i][{a, 1'b1}]), 32'(ref_mem[i][{a, 1'b1}]));
    end
  endtask

  // Reset in the first WE-low cycle of a write on the default instance.
  task automatic abort_test();
    logic [16:0] a;
    logic [15:0] old_lo, got;
    bit seen_we, acked;
    a = 17'h00100;
    old_lo = ref_mem[0][{a, 1'b0}];
    bus_addr[0] = a; bus_be[0] = 4'hF; bus_wdata[0] = 32'h12345678; bus_wr[0] = 1'b1;
    seen_we = 1'b0;
    for (int n = 0; n < 20 && !seen_we; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (!sram_we_n[0]) seen_we = 1'b1;
    end
    check("abort_we_seen", 32'(seen_we), 32'd1);
    rst[0] = 1'b1; bus_wr[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_ctrl", {27'd0, sram_ce_n[0], sram_oe_n[0], sram_we_n[0], sram_lb_n[0], sram_ub_n[0]}, 32'h1F);
    check("abort_rdata", bus_rdata[0], 32'h0);
    rst[0] = 1'b0;
    last_rd[0] = 32'h0;
    acked = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_ack[0]) acked = 1'b1;
    end
    check("abort_no_ack", 32'(acked), 32'd0);
    got = sram_mem[0][{a, 1'b0}];
    check("abort_mem_old_or_new", 32'(got == old_lo || got == 16'h5678), 32'd1);
    check("abort_mem_hi", 32'(sram_mem[0][{a, 1'b1}]), 32'(ref_mem[0][{a, 1'b1}]));
    ref_mem[0][{a, 1'b0}] = got;
    do_txn(0, 1'b0, 1'b1, a, 4'hF, 32'h0);
  endtask

  initial begin
    logic wr, rd;
    logic [3:0] be;
    logic [16:0] a;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; bus_addr[i] = '0; bus_be[i] = '0; bus_wdata[i] = '0;
      bus_rd[i] = 1'b0; bus_wr[i] = 1'b0; last_rd[i] = 32'h0;
      pend_v[i] = 1'b0; we_len[i] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_ctrl", {27'd0, sram_ce_n[i], sram_oe_n[i], sram_we_n[i], sram_lb_n[i], sram_ub_n[i]}, 32'h1F);
      check("rst_ack", 32'(bus_ack[i]), 32'd0);
      check("rst_rdata", bus_rdata[i], 32'h0);
      check("rst_addr", 32'(sram_addr[i]), 32'h0);
      rst[i] = 1'b0;
    end
    mon_en = 1'b1;

    for (int i = 0; i < 2; i++) begin
      do_txn(i, 1'b1, 1'b0, 17'h00010, 4'hF, 32'hDEADBEEF);
      check("word_lo", 32'(sram_mem[i][18'h00020]), 32'h0000BEEF);
      check("word_hi", 32'(sram_mem[i][18'h00021]), 32'h0000DEAD);
      do_txn(i, 1'b0, 1'b1, 17'h00010, 4'hF, 32'h0);
      check("read_full", bus_rdata[i], 32'hDEADBEEF);
      do_txn(i, 1'b1, 1'b0, 17'h00010, 4'b0100, 32'h00AA0000);
      do_txn(i, 1'b0, 1'b1, 17'h00010, 4'hF, 32'h0);
      check("read_byte", bus_rdata[i], 32'hDEAABEEF);
      do_txn(i, 1'b0, 1'b1, 17'h00010, 4'b0011, 32'h0);
      check("read_lo_only", bus_rdata[i], 32'h0000BEEF);
      do_txn(i, 1'b1, 1'b1, 17'h00020, 4'hF, 32'hCAFEF00D);
      check("wr_priority", 32'(sram_mem[i][18'h00040]), 32'h0000F00D);
      do_txn(i, 1'b1, 1'b1, 17'h00020, 4'h0, 32'h11111111);
    end

    abort_test();

    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 150; n++) begin
        wr = 1'($urandom_range(0, 1));
        rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        be = wr ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 15));
        a  = ($urandom_range(0, 3) == 0) ? 17'($urandom_range(0, 131071)) : 17'($urandom_range(0, 31));
        do_txn(i, wr, rd, a, be, $urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
